// File: rtl/mem_access_stage_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_stage_pkg
//  Purpose : Shared definitions for the RV32I MEM stage. This package holds
//            the memory-access FSM state encoding, the write-back mux select
//            codes and a small address-alignment helper.
//  Rev     : 1.0  initial release
// ============================================================================
package mem_access_stage_pkg;

    // Memory-access FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,   // no access outstanding; request issued combinationally
        ST_REQ  = 2'd1,   // request presented, waiting for dmem_req_ready
        ST_WAIT = 2'd2    // load accepted, waiting for dmem_rsp_valid
    } mem_state_e;

    // Write-back mux select codes carried through MEM/WB
    localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
    localparam logic [1:0] MEM_TO_REG_MEM = 2'b01;

    // True when the low address bits select a whole 32-bit word
    function automatic logic is_word_aligned(input logic [1:0] i_addr_lsb);
        return (i_addr_lsb == 2'b00);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_stage_fsm.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_fsm
//  Purpose : Valid/ready data-memory handshake sequencer for the MEM stage.
//            It issues the request, tracks an outstanding load until its
//            response arrives, and produces the done and stall indications.
//  Ports   : clk, reset (async, active-low)
//            i_access     - instruction needs a memory access this cycle
//            i_store      - 1 = store, 0 = load
//            i_req_ready  - memory accepts the request
//            i_rsp_valid  - load response valid (only looked at in WAIT)
//            o_req_valid  - memory request valid
//            o_done       - access completes this cycle
//            o_stall      - hold the upstream pipeline this cycle
//  Rev     : 1.0  initial release
// ============================================================================
module mem_access_fsm
    import mem_access_stage_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic i_access,
    input  logic i_store,
    input  logic i_req_ready,
    input  logic i_rsp_valid,
    output logic o_req_valid,
    output logic o_done,
    output logic o_stall
);

    mem_state_e r_state;
    mem_state_e w_next_state;
    logic       w_req_valid;
    logic       w_done;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_req_valid  = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_req_valid = i_access;
                if (i_access) begin
                    if (i_req_ready) begin
                        // A store completes on acceptance; a load must wait for data
                        if (i_store) begin
                            w_done = 1'b1;
                        end else begin
                            w_next_state = ST_WAIT;
                        end
                    end else begin
                        w_next_state = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                w_req_valid = 1'b1;
                if (!i_access) begin
                    // Upstream is frozen while stalled, so this only happens
                    // if the instruction was squashed; abandon cleanly.
                    w_req_valid  = 1'b0;
                    w_next_state = ST_IDLE;
                end else if (i_req_ready) begin
                    if (i_store) begin
                        w_done       = 1'b1;
                        w_next_state = ST_IDLE;
                    end else begin
                        w_next_state = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!i_access) begin
                    w_next_state = ST_IDLE;
                end else if (i_rsp_valid) begin
                    w_done       = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign o_req_valid = w_req_valid;
    assign o_done      = w_done;
    assign o_stall     = i_access & ~w_done;

endmodule
`default_nettype wire

// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module  : mem_access_stage
//  Purpose : MEM stage of the 5-stage RV32I pipeline. Performs loads/stores
//            over a valid/ready data-memory port, stalls upstream while an
//            access is outstanding, resolves the branch decision and holds
//            the MEM/WB pipeline register.
//  Config  : MEM_ALIGN_CHECK_EN - when defined, accesses with a non-zero
//            alu_result_in[1:0] issue no request, do not stall, pulse mem_err
//            for one cycle and retire with wb_regwrite = 0. When undefined,
//            no check is made and mem_err is tied 0.
//  Ports   : clk, reset (async, active-low)
//            EX/MEM inputs : regwrite_in, mem_read_in, mem_write_in,
//                            mem_to_reg_in, branch_in, zero_flag_in,
//                            alu_result_in, branch_target_in, write_data_in,
//                            rd_in
//            Data memory   : dmem_req_valid/ready, dmem_we, dmem_addr,
//                            dmem_wdata, dmem_rsp_valid, dmem_rdata
//            Hazard/branch : stall_out, pc_src, branch_target_out, flush_out
//            MEM/WB        : wb_regwrite, wb_mem_to_reg, wb_alu_result,
//                            wb_read_data, wb_rd, mem_err
//  Rev     : 1.0  initial release
// ============================================================================
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  regwrite_in,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic [1:0]            mem_to_reg_in,
    input  logic                  branch_in,
    input  logic                  zero_flag_in,
    input  logic [XLEN-1:0]       alu_result_in,
    input  logic [XLEN-1:0]       branch_target_in,
    input  logic [XLEN-1:0]       write_data_in,
    input  logic [REG_ADDR_W-1:0] rd_in,
    output logic                  dmem_req_valid,
    input  logic                  dmem_req_ready,
    output logic                  dmem_we,
    output logic [XLEN-1:0]       dmem_addr,
    output logic [XLEN-1:0]       dmem_wdata,
    input  logic                  dmem_rsp_valid,
    input  logic [XLEN-1:0]       dmem_rdata,
    output logic                  stall_out,
    output logic                  pc_src,
    output logic [XLEN-1:0]       branch_target_out,
    output logic                  flush_out,
    output logic                  wb_regwrite,
    output logic [1:0]            wb_mem_to_reg,
    output logic [XLEN-1:0]       wb_alu_result,
    output logic [XLEN-1:0]       wb_read_data,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  mem_err
);

    logic w_access;
    logic w_misaligned;
    logic w_fsm_access;
    logic w_done;
    logic w_stall;

    logic                  r_wb_regwrite;
    logic [1:0]            r_wb_mem_to_reg;
    logic [XLEN-1:0]       r_wb_alu_result;
    logic [XLEN-1:0]       r_wb_read_data;
    logic [REG_ADDR_W-1:0] r_wb_rd;

    assign w_access = mem_read_in | mem_write_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign w_misaligned = w_access & ~is_word_aligned(alu_result_in[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // A misaligned access never reaches memory, so the FSM does not see it
    assign w_fsm_access = w_access & ~w_misaligned;

    mem_access_fsm u_fsm (
        .clk         (clk),
        .reset       (reset),
        .i_access    (w_fsm_access),
        .i_store     (mem_write_in),
        .i_req_ready (dmem_req_ready),
        .i_rsp_valid (dmem_rsp_valid),
        .o_req_valid (dmem_req_valid),
        .o_done      (w_done),
        .o_stall     (w_stall)
    );

    assign dmem_we    = mem_write_in;
    assign dmem_addr  = alu_result_in;
    assign dmem_wdata = write_data_in;
    assign stall_out  = w_stall;

    // Branches never touch memory, so the redirect is not gated by stall
    assign pc_src            = branch_in & zero_flag_in;
    assign flush_out         = pc_src;
    assign branch_target_out = branch_target_in;

    // MEM/WB register. While stalled a bubble is inserted so the held
    // instruction retires exactly once, on the cycle its access completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wb_regwrite   <= 1'b0;
            r_wb_mem_to_reg <= MEM_TO_REG_ALU;
            r_wb_alu_result <= '0;
            r_wb_read_data  <= '0;
            r_wb_rd         <= '0;
        end else if (w_stall) begin
            r_wb_regwrite   <= 1'b0;
            r_wb_mem_to_reg <= MEM_TO_REG_ALU;
            r_wb_alu_result <= '0;
            r_wb_read_data  <= '0;
            r_wb_rd         <= '0;
        end else begin
            r_wb_regwrite   <= regwrite_in & ~w_misaligned;
            r_wb_mem_to_reg <= mem_to_reg_in;
            r_wb_alu_result <= alu_result_in;
            r_wb_read_data  <= (mem_read_in & ~w_misaligned) ? dmem_rdata : '0;
            r_wb_rd         <= rd_in;
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    logic r_mem_err;

    // A misaligned access does not stall, so this is a single-cycle pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= w_misaligned;
        end
    end

    assign mem_err = r_mem_err;
`else
    assign mem_err = 1'b0;
`endif

    assign wb_regwrite   = r_wb_regwrite;
    assign wb_mem_to_reg = r_wb_mem_to_reg;
    assign wb_alu_result = r_wb_alu_result;
    assign wb_read_data  = r_wb_read_data;
    assign wb_rd         = r_wb_rd;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
//  Module  : tb_mem_access_stage
//  Purpose : Self-checking bench for mem_access_stage: directed vectors,
//            multi-cycle load/store/reset sequences and randomized
//            transactions checked against a transaction-level model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_mem_access_stage;

`ifdef MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_EN = 1'b1;
`else
    localparam bit ALIGN_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        regwrite_in, mem_read_in, mem_write_in;
    logic [1:0]  mem_to_reg_in;
    logic        branch_in, zero_flag_in;
    logic [31:0] alu_result_in, branch_target_in, write_data_in;
    logic [4:0]  rd_in;
    logic        dmem_req_valid, dmem_req_ready, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic        dmem_rsp_valid;
    logic [31:0] dmem_rdata;
    logic        stall_out, pc_src, flush_out;
    logic [31:0] branch_target_out;
    logic        wb_regwrite;
    logic [1:0]  wb_mem_to_reg;
    logic [31:0] wb_alu_result, wb_read_data;
    logic [4:0]  wb_rd;
    logic        mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_access_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .reset(reset),
        .regwrite_in(regwrite_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_to_reg_in(mem_to_reg_in), .branch_in(branch_in), .zero_flag_in(zero_flag_in),
        .alu_result_in(alu_result_in), .branch_target_in(branch_target_in),
        .write_data_in(write_data_in), .rd_in(rd_in),
        .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .pc_src(pc_src), .branch_target_out(branch_target_out),
        .flush_out(flush_out),
        .wb_regwrite(wb_regwrite), .wb_mem_to_reg(wb_mem_to_reg), .wb_alu_result(wb_alu_result),
        .wb_read_data(wb_read_data), .wb_rd(wb_rd), .mem_err(mem_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        regwrite_in = 0; mem_read_in = 0; mem_write_in = 0; mem_to_reg_in = 2'b00;
        branch_in = 0; zero_flag_in = 0; alu_result_in = 0; branch_target_in = 0;
        write_data_in = 0; rd_in = 0; dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
    endtask

    // advance to 1 time unit after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_wb(input string tag, input logic rw, input logic [1:0] m2r,
                          input logic [31:0] alu, input logic [31:0] rdat, input logic [4:0] rd);
        chk({tag, ".wb_regwrite"},   wb_regwrite,   rw);
        chk({tag, ".wb_mem_to_reg"}, wb_mem_to_reg, m2r);
        chk({tag, ".wb_alu_result"}, wb_alu_result, alu);
        chk({tag, ".wb_read_data"},  wb_read_data,  rdat);
        chk({tag, ".wb_rd"},         wb_rd,         rd);
    endtask

    typedef struct {
        logic        rw, rd_en, wr_en;
        logic [1:0]  m2r;
        logic        br, zf;
        logic [31:0] alu, tgt, wd;
        logic [4:0]  rd;
        logic        e_stall, e_req, e_pc;
        logic        e_rw;
    } vec_t;

    vec_t vecs[6];

    initial begin
        clr();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        // ---------------- reset state ----------------
        chk_wb("reset", 0, 2'b00, 0, 0, 0);
        chk("reset.mem_err", mem_err, 0);
        chk("reset.req_valid", dmem_req_valid, 0);
        reset = 1'b1;

        // ---------------- single-cycle vectors ----------------
        //           rw rd wr m2r   br zf alu           tgt        wd            rd  stall req pc  e_rw
        vecs[0] = '{1, 0, 0, 2'b00, 0, 0, 32'h1234,     32'h0,     32'h0,        5,  0,    0,  0,  1};
        vecs[1] = '{0, 0, 0, 2'b00, 1, 1, 32'h0,        32'hFF0,   32'h0,        0,  0,    0,  1,  0};
        vecs[2] = '{0, 0, 0, 2'b00, 1, 0, 32'h4,        32'hFF0,   32'h0,        0,  0,    0,  0,  0};
        vecs[3] = '{0, 0, 1, 2'b00, 0, 0, 32'h200,      32'h0,     32'hCAFEF00D, 3,  0,    1,  0,  0};
        vecs[4] = '{1, 0, 0, 2'b00, 0, 1, 32'hFFFFFFFF, 32'h80,    32'h0,        31, 0,    0,  0,  1};
        vecs[5] = '{0, 0, 0, 2'b00, 0, 0, 32'h55,       32'h0,     32'h0,        0,  0,    0,  0,  0};
        foreach (vecs[i]) begin
            regwrite_in = vecs[i].rw; mem_read_in = vecs[i].rd_en; mem_write_in = vecs[i].wr_en;
            mem_to_reg_in = vecs[i].m2r; branch_in = vecs[i].br; zero_flag_in = vecs[i].zf;
            alu_result_in = vecs[i].alu; branch_target_in = vecs[i].tgt;
            write_data_in = vecs[i].wd; rd_in = vecs[i].rd; dmem_req_ready = 1'b1;
            #4;
            chk($sformatf("vec%0d.stall", i), stall_out, vecs[i].e_stall);
            chk($sformatf("vec%0d.req_valid", i), dmem_req_valid, vecs[i].e_req);
            chk($sformatf("vec%0d.pc_src", i), pc_src, vecs[i].e_pc);
            chk($sformatf("vec%0d.flush", i), flush_out, vecs[i].e_pc);
            chk($sformatf("vec%0d.target", i), branch_target_out, vecs[i].tgt);
            chk($sformatf("vec%0d.addr", i), dmem_addr, vecs[i].alu);
            tick();
            chk_wb($sformatf("vec%0d", i), vecs[i].e_rw, vecs[i].m2r, vecs[i].alu, 0, vecs[i].rd);
        end
        clr();

        // ---------------- load, response 2 cycles after acceptance ----------------
        regwrite_in = 1; mem_read_in = 1; mem_to_reg_in = 2'b01; alu_result_in = 32'h100;
        rd_in = 7; dmem_req_ready = 1;
        #4;
        chk("ld.c0.stall", stall_out, 1);
        chk("ld.c0.req_valid", dmem_req_valid, 1);
        chk("ld.c0.we", dmem_we, 0);
        chk("ld.c0.addr", dmem_addr, 32'h100);
        tick();
        chk_wb("ld.c0", 0, 2'b00, 0, 0, 0);
        dmem_req_ready = 0;
        #4;
        chk("ld.c1.stall", stall_out, 1);
        chk("ld.c1.req_valid", dmem_req_valid, 0);
        tick();
        chk_wb("ld.c1", 0, 2'b00, 0, 0, 0);
        dmem_rsp_valid = 1; dmem_rdata = 32'hDEADBEEF;
        #4;
        chk("ld.c2.stall", stall_out, 0);
        tick();
        chk_wb("ld.done", 1, 2'b01, 32'h100, 32'hDEADBEEF, 7);
        clr();

        // ---------------- store, ready low for 3 cycles ----------------
        mem_write_in = 1; alu_result_in = 32'h200; write_data_in = 32'hCAFEF00D; rd_in = 2;
        for (int c = 0; c < 3; c++) begin
            #4;
            chk($sformatf("st.c%0d.stall", c), stall_out, 1);
            chk($sformatf("st.c%0d.req_valid", c), dmem_req_valid, 1);
            chk($sformatf("st.c%0d.we", c), dmem_we, 1);
            chk($sformatf("st.c%0d.addr", c), dmem_addr, 32'h200);
            chk($sformatf("st.c%0d.wdata", c), dmem_wdata, 32'hCAFEF00D);
            tick();
            chk($sformatf("st.c%0d.wb_alu", c), wb_alu_result, 0);
        end
        dmem_req_ready = 1;
        #4;
        chk("st.acc.stall", stall_out, 0);
        chk("st.acc.req_valid", dmem_req_valid, 1);
        tick();
        chk_wb("st.done", 0, 2'b00, 32'h200, 0, 2);
        clr();

        // ---------------- reset asserted while waiting for load data ----------------
        regwrite_in = 1; mem_read_in = 1; mem_to_reg_in = 2'b01; alu_result_in = 32'h300;
        rd_in = 9; dmem_req_ready = 1;
        tick();
        dmem_req_ready = 0;
        #4;
        chk("rst.wait.stall", stall_out, 1);
        reset = 1'b0;
        clr();
        #1;
        chk_wb("rst.async", 0, 2'b00, 0, 0, 0);
        chk("rst.async.req_valid", dmem_req_valid, 0);
        tick();
        tick();
        reset = 1'b1;
        dmem_rsp_valid = 1; dmem_rdata = 32'hBAD0BAD0;
        #4;
        chk("rst.late.stall", stall_out, 0);
        chk("rst.late.req_valid", dmem_req_valid, 0);
        tick();
        chk_wb("rst.late", 0, 2'b00, 0, 0, 0);
        // A fresh load with a stray response in the same cycle must still stall
        regwrite_in = 1; mem_read_in = 1; mem_to_reg_in = 2'b01; alu_result_in = 32'h304;
        rd_in = 4; dmem_req_ready = 1; dmem_rsp_valid = 1;
        #4;
        chk("rst.idle.stall", stall_out, 1);
        tick();
        dmem_rdata = 32'h01234567;
        #4;
        chk("rst.next.stall", stall_out, 0);
        tick();
        chk_wb("rst.next", 1, 2'b01, 32'h304, 32'h01234567, 4);
        clr();

`ifdef MEM_ALIGN_CHECK_EN
        // ---------------- misaligned load ----------------
        regwrite_in = 1; mem_read_in = 1; mem_to_reg_in = 2'b01; alu_result_in = 32'h102;
        rd_in = 6; dmem_req_ready = 1;
        #4;
        chk("mis.req_valid", dmem_req_valid, 0);
        chk("mis.stall", stall_out, 0);
        tick();
        chk("mis.mem_err", mem_err, 1);
        chk("mis.wb_regwrite", wb_regwrite, 0);
        clr();
        tick();
        chk("mis.mem_err_clr", mem_err, 0);
`endif

        // ---------------- randomized transactions ----------------
        for (int t = 0; t < 250; t++) begin
            int          kind, d, r, n_stall;
            logic        mis, eacc, is_ld, is_st;
            logic [31:0] last_rdata;
            kind = $urandom_range(0, 3);
            is_ld = (kind == 2);
            is_st = (kind == 3);
            regwrite_in   = is_st ? 1'b0 : (is_ld ? 1'b1 : 1'($urandom_range(0, 1)));
            mem_read_in   = is_ld;
            mem_write_in  = is_st;
            mem_to_reg_in = is_ld ? 2'b01 : 2'b00;
            branch_in     = (kind == 1);
            zero_flag_in  = 1'($urandom_range(0, 1));
            alu_result_in = $urandom;
            if ($urandom_range(0, 3) != 0) alu_result_in[1:0] = 2'b00;
            branch_target_in = $urandom;
            write_data_in    = $urandom;
            rd_in            = 5'($urandom_range(0, 31));
            d = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            mis  = ALIGN_EN && (is_ld || is_st) && (alu_result_in[1:0] != 2'b00);
            eacc = (is_ld || is_st) && !mis;
            n_stall = !eacc ? 0 : (is_st ? d : d + 1 + r);
            last_rdata = 0;
            for (int c = 0; c <= n_stall; c++) begin
                dmem_rdata = $urandom;
                if (eacc && c <= d) dmem_req_ready = (c == d);
                else                dmem_req_ready = 1'($urandom_range(0, 1));
                if (eacc && is_ld && c > d) dmem_rsp_valid = (c == d + 1 + r);
                else                        dmem_rsp_valid = 1'($urandom_range(0, 1));
                last_rdata = dmem_rdata;
                #4;
                chk($sformatf("rnd%0d.c%0d.stall", t, c), stall_out, (c < n_stall));
                chk($sformatf("rnd%0d.c%0d.req_valid", t, c), dmem_req_valid, (eacc && c <= d));
                chk($sformatf("rnd%0d.pc_src", t), pc_src, branch_in & zero_flag_in);
                tick();
                if (c < n_stall) begin
                    chk($sformatf("rnd%0d.c%0d.bubble_rw", t, c), wb_regwrite, 0);
                    chk($sformatf("rnd%0d.c%0d.bubble_alu", t, c), wb_alu_result, 0);
                end else begin
                    chk_wb($sformatf("rnd%0d", t), regwrite_in & !mis, mem_to_reg_in, alu_result_in,
                           (is_ld && !mis) ? last_rdata : 32'h0, rd_in);
                    chk($sformatf("rnd%0d.mem_err", t), mem_err, mis);
                end
            end
        end
        clr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global watchdog so the run always ends
    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
